// File: rtl/mvm_engine_if.sv
// ---------------------------------------------------------------------------
// mvm_engine_if
// Interface for the matrix-vector multiply engine. It carries the job
// request, the operands and the results.
//   i_start_mvmEng : start request; the engine samples it on the rising edge
//   i_accum        : sampled with start; 1 = keep accumulators, 0 = clear them
//   i_matrix       : W[r][c], signed NUM_BIT; the engine latches it at start
//   i_vector       : x[c], signed NUM_BIT; the engine latches it at start
//   o_y_vector     : y[r], signed OUT_W results
//   o_busy         : high while a job is in progress
//   o_done         : one-cycle completion pulse
//   o_sat          : at least one row saturated in the last result
// Modports: master (job source) and slave (engine).
// ---------------------------------------------------------------------------
interface mvm_engine_if #(
    parameter int NUM_BIT = 8,
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int OUT_W   = 16
);
    logic                                       i_start_mvmEng;
    logic                                       i_accum;
    logic [ROWS-1:0][COLS-1:0][NUM_BIT-1:0]     i_matrix;
    logic [COLS-1:0][NUM_BIT-1:0]               i_vector;
    logic [ROWS-1:0][OUT_W-1:0]                 o_y_vector;
    logic                                       o_busy;
    logic                                       o_done;
    logic                                       o_sat;

    modport master (
        output i_start_mvmEng, i_accum, i_matrix, i_vector,
        input  o_y_vector, o_busy, o_done, o_sat
    );

    modport slave (
        input  i_start_mvmEng, i_accum, i_matrix, i_vector,
        output o_y_vector, o_busy, o_done, o_sat
    );
endinterface

// File: rtl/mvm_engine.sv
// ---------------------------------------------------------------------------
// mvm_engine
// Signed fixed-point matrix-vector multiply: y[r] = sum_c W[r][c]*x[c].
// Each RUN cycle consumes LANES columns across every row. The result is
// arithmetically shifted right by SHIFT and saturated to OUT_W bits.
// Accumulators can be kept across successive starts (tile accumulation).
// Ports:
//   i_clk_mvmEng : clock
//   i_rst_mvmEng : asynchronous reset, active-high
//   bus          : mvm_engine_if slave (start/accum/operands in, results out)
// Latency: start sampled at edge k; o_done and o_y_vector update at
// edge k+STEPS+1, where STEPS = ceil(COLS/LANES).
// ---------------------------------------------------------------------------
module mvm_engine #(
    parameter int NUM_BIT = 8,
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int LANES   = 2,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 7,
    parameter int GUARD   = 4
) (
    input  logic         i_clk_mvmEng,
    input  logic         i_rst_mvmEng,
    mvm_engine_if.slave  bus
);

    localparam int ACC_W  = 2*NUM_BIT + $clog2(COLS) + GUARD;
    localparam int STEPS  = (COLS + LANES - 1) / LANES;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    // Saturation limits sign-extended to accumulator width (MIN == ~MAX).
    localparam logic signed [ACC_W-1:0] Y_MAX =
        signed'(ACC_W'({1'b0, {(OUT_W-1){1'b1}}}));
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Signed product, sign-extended to full accumulator width.
    function automatic logic signed [ACC_W-1:0] prod_ext(
        input logic [NUM_BIT-1:0] w,
        input logic [NUM_BIT-1:0] x
    );
        logic signed [2*NUM_BIT-1:0] p;
        p = signed'(w) * signed'(x);
        return ACC_W'(p);
    endfunction

    // Floor shift then clamp; returns {saturated_flag, value}.
    function automatic logic [OUT_W:0] shift_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] shifted;
        logic [OUT_W:0]          res;
        shifted = acc >>> SHIFT;
        if (shifted > Y_MAX) begin
            res = {1'b1, Y_MAX[OUT_W-1:0]};
        end else if (shifted < Y_MIN) begin
            res = {1'b1, Y_MIN[OUT_W-1:0]};
        end else begin
            res = {1'b0, shifted[OUT_W-1:0]};
        end
        return res;
    endfunction

    state_t                                 state_q, state_d;
    logic [STEP_W-1:0]                      step_q, step_d;
    logic [ROWS-1:0][COLS-1:0][NUM_BIT-1:0] mat_q, mat_d;
    logic [COLS-1:0][NUM_BIT-1:0]           vec_q, vec_d;
    logic signed [ACC_W-1:0]                acc_q [ROWS];
    logic signed [ACC_W-1:0]                acc_d [ROWS];
    logic [ROWS-1:0][OUT_W-1:0]             y_q, y_d;
    logic                                   busy_q, busy_d;
    logic                                   done_q, done_d;
    logic                                   sat_q, sat_d;

    logic signed [ACC_W-1:0]                row_sum_s [ROWS];
    logic [OUT_W:0]                         out_res_s [ROWS];
    logic                                   out_sat_s;

    // Per-row contribution of the current column chunk. Columns outside the
    // chunk (including the missing columns of a partial last chunk) add 0.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_sum_s[r] = {ACC_W{1'b0}};
            for (int c = 0; c < COLS; c++) begin
                row_sum_s[r] = row_sum_s[r] +
                    (((c / LANES) == int'(step_q)) ?
                        prod_ext(mat_q[r][c], vec_q[c]) : {ACC_W{1'b0}});
            end
        end
    end

    // Shifted/saturated view of the accumulators and the combined sat flag.
    always_comb begin
        out_sat_s = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            out_res_s[r] = shift_sat(acc_q[r]);
            out_sat_s    = out_sat_s | out_res_s[r][OUT_W];
        end
    end

    // Next-state and next-output computation for the IDLE/RUN/OUT sequence.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        mat_d   = mat_q;
        vec_d   = vec_q;
        acc_d   = acc_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sat_d   = sat_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start_mvmEng) begin
                    mat_d = bus.i_matrix;
                    vec_d = bus.i_vector;
                    if (bus.i_accum) begin
                        acc_d = acc_q;
                    end else begin
                        for (int r = 0; r < ROWS; r++) begin
                            acc_d[r] = {ACC_W{1'b0}};
                        end
                    end
                    step_d  = {STEP_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                for (int r = 0; r < ROWS; r++) begin
                    acc_d[r] = acc_q[r] + row_sum_s[r];
                end
                if (step_q == LAST_STEP) begin
                    step_d  = {STEP_W{1'b0}};
                    state_d = ST_OUT;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = ST_RUN;
                end
            end

            ST_OUT: begin
                for (int r = 0; r < ROWS; r++) begin
                    y_d[r] = out_res_s[r][OUT_W-1:0];
                end
                sat_d   = out_sat_s;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                step_d  = {STEP_W{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, operand, accumulator and output registers.
    always_ff @(posedge i_clk_mvmEng or posedge i_rst_mvmEng) begin
        if (i_rst_mvmEng) begin
            state_q <= ST_IDLE;
            step_q  <= {STEP_W{1'b0}};
            mat_q   <= '0;
            vec_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= {ACC_W{1'b0}};
            end
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.o_y_vector = y_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_sat      = sat_q;

endmodule

// File: tb/tb_mvm_engine.sv
// ---------------------------------------------------------------------------
// tb_mvm_engine
// Bench for mvm_engine using three instances:
//   dut 0 : defaults (SHIFT=7)
//   dut 1 : SHIFT=0
//   dut 2 : COLS=7, LANES=2, SHIFT=0 (partial last chunk)
// A vector table drives jobs, and a scoreboard queue holds the expected
// result of each job. Hand-written sequences cover a start pulsed mid-RUN
// and a reset asserted mid-RUN.
// ---------------------------------------------------------------------------
module tb_mvm_engine;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mvm_engine_if #(.NUM_BIT(8), .ROWS(8), .COLS(8), .OUT_W(16)) bus_a ();
    mvm_engine_if #(.NUM_BIT(8), .ROWS(8), .COLS(8), .OUT_W(16)) bus_b ();
    mvm_engine_if #(.NUM_BIT(8), .ROWS(8), .COLS(7), .OUT_W(16)) bus_c ();

    mvm_engine #(.NUM_BIT(8), .ROWS(8), .COLS(8), .LANES(2), .OUT_W(16),
                 .SHIFT(7), .GUARD(4)) u_dut_a (
        .i_clk_mvmEng (clk),
        .i_rst_mvmEng (rst),
        .bus          (bus_a)
    );

    mvm_engine #(.NUM_BIT(8), .ROWS(8), .COLS(8), .LANES(2), .OUT_W(16),
                 .SHIFT(0), .GUARD(4)) u_dut_b (
        .i_clk_mvmEng (clk),
        .i_rst_mvmEng (rst),
        .bus          (bus_b)
    );

    mvm_engine #(.NUM_BIT(8), .ROWS(8), .COLS(7), .LANES(2), .OUT_W(16),
                 .SHIFT(0), .GUARD(4)) u_dut_c (
        .i_clk_mvmEng (clk),
        .i_rst_mvmEng (rst),
        .bus          (bus_c)
    );

    // wpat: 0 = all W=wv, x=xv; 1 = W[r][c]=r+1, x[c]=c+1;
    //       2 = W[r][c] = (c odd ? -16 : 16), x=xv
    typedef struct {
        int dut;
        bit accum;
        int wpat;
        int wv;
        int xv;
        int y0;
        int ystep;
        bit sat;
        int lat;
    } vec_t;

    typedef struct {
        int dut;
        int y0;
        int ystep;
        bit sat;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int w_of(input int wpat, input int wv, input int r, input int c);
        case (wpat)
            1:       return r + 1;
            2:       return ((c % 2) == 1) ? -16 : 16;
            default: return wv;
        endcase
    endfunction

    function automatic int x_of(input int wpat, input int xv, input int c);
        return (wpat == 1) ? (c + 1) : xv;
    endfunction

    task automatic set_ops(input int dut, input bit accum, input int wpat,
                           input int wv, input int xv);
        case (dut)
            0: begin
                bus_a.i_accum = accum;
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        bus_a.i_matrix[r][c] = 8'(w_of(wpat, wv, r, c));
                for (int c = 0; c < 8; c++) bus_a.i_vector[c] = 8'(x_of(wpat, xv, c));
            end
            1: begin
                bus_b.i_accum = accum;
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        bus_b.i_matrix[r][c] = 8'(w_of(wpat, wv, r, c));
                for (int c = 0; c < 8; c++) bus_b.i_vector[c] = 8'(x_of(wpat, xv, c));
            end
            default: begin
                bus_c.i_accum = accum;
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 7; c++)
                        bus_c.i_matrix[r][c] = 8'(w_of(wpat, wv, r, c));
                for (int c = 0; c < 7; c++) bus_c.i_vector[c] = 8'(x_of(wpat, xv, c));
            end
        endcase
    endtask

    task automatic set_start(input int dut, input bit v);
        case (dut)
            0:       bus_a.i_start_mvmEng = v;
            1:       bus_b.i_start_mvmEng = v;
            default: bus_c.i_start_mvmEng = v;
        endcase
    endtask

    function automatic int get_done(input int dut);
        case (dut)
            0:       return int'(bus_a.o_done);
            1:       return int'(bus_b.o_done);
            default: return int'(bus_c.o_done);
        endcase
    endfunction

    function automatic int get_busy(input int dut);
        case (dut)
            0:       return int'(bus_a.o_busy);
            1:       return int'(bus_b.o_busy);
            default: return int'(bus_c.o_busy);
        endcase
    endfunction

    function automatic int get_sat(input int dut);
        case (dut)
            0:       return int'(bus_a.o_sat);
            1:       return int'(bus_b.o_sat);
            default: return int'(bus_c.o_sat);
        endcase
    endfunction

    function automatic int get_y(input int dut, input int r);
        case (dut)
            0:       return int'($signed(bus_a.o_y_vector[r]));
            1:       return int'($signed(bus_b.o_y_vector[r]));
            default: return int'($signed(bus_c.o_y_vector[r]));
        endcase
    endfunction

    // Runs one job; if glitch != 0 a second start with different operands is
    // pulsed at that cycle of RUN and must have no effect.
    task automatic run_job(input int dut, input bit accum, input int wpat,
                           input int wv, input int xv, input exp_t e,
                           input int glitch);
        exp_t got;
        int   cyc;
        int   seen;
        int   extra;
        exp_q.push_back(e);
        @(negedge clk);
        set_ops(dut, accum, wpat, wv, xv);
        set_start(dut, 1'b1);
        @(posedge clk);
        #1;
        set_start(dut, 1'b0);
        cyc  = 0;
        seen = 0;
        while (cyc < 20 && seen == 0) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) chk($sformatf("dut%0d_busy_run", dut), get_busy(dut), 1);
            if (get_done(dut) == 1) begin
                seen = 1;
            end else if (glitch != 0 && cyc == glitch) begin
                set_ops(dut, 1'b0, 0, 127, 127);
                set_start(dut, 1'b1);
            end else begin
                set_start(dut, 1'b0);
            end
        end
        set_start(dut, 1'b0);
        got = exp_q.pop_front();
        chk($sformatf("dut%0d_done_seen", dut), seen, 1);
        if (seen == 1) begin
            chk($sformatf("dut%0d_latency", dut), cyc, got.lat);
            for (int r = 0; r < 8; r++)
                chk($sformatf("dut%0d_y%0d", dut, r), get_y(dut, r), got.y0 + r * got.ystep);
            chk($sformatf("dut%0d_sat", dut), get_sat(dut), int'(got.sat));
            chk($sformatf("dut%0d_busy_done", dut), get_busy(dut), 0);
            @(posedge clk);
            #1;
            chk($sformatf("dut%0d_done_pulse", dut), get_done(dut), 0);
            chk($sformatf("dut%0d_y0_hold", dut), get_y(dut, 0), got.y0);
        end
        if (glitch != 0) begin
            extra = 0;
            repeat (8) begin
                @(posedge clk);
                #1;
                extra += get_done(dut);
            end
            chk($sformatf("dut%0d_no_extra_done", dut), extra, 0);
        end
    endtask

    vec_t tbl [7];

    initial begin
        exp_t e;
        int   nz;
        checks   = 0;
        failures = 0;

        tbl[0] = '{dut:0, accum:1'b0, wpat:0, wv:64,   xv:64,  y0:256,    ystep:0,  sat:1'b0, lat:5};
        tbl[1] = '{dut:0, accum:1'b1, wpat:0, wv:64,   xv:64,  y0:512,    ystep:0,  sat:1'b0, lat:5};
        tbl[2] = '{dut:0, accum:1'b0, wpat:0, wv:64,   xv:64,  y0:256,    ystep:0,  sat:1'b0, lat:5};
        tbl[3] = '{dut:1, accum:1'b0, wpat:0, wv:127,  xv:127, y0:32767,  ystep:0,  sat:1'b1, lat:5};
        tbl[4] = '{dut:1, accum:1'b0, wpat:0, wv:-128, xv:127, y0:-32768, ystep:0,  sat:1'b1, lat:5};
        tbl[5] = '{dut:2, accum:1'b0, wpat:1, wv:0,    xv:0,   y0:28,     ystep:28, sat:1'b0, lat:5};
        tbl[6] = '{dut:1, accum:1'b0, wpat:2, wv:0,    xv:32,  y0:0,      ystep:0,  sat:1'b0, lat:5};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            set_start(d, 1'b0);
            set_ops(d, 1'b0, 0, 0, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            nz = 0;
            for (int r = 0; r < 8; r++) nz += (get_y(d, r) != 0) ? 1 : 0;
            chk($sformatf("dut%0d_rst_y", d), nz, 0);
            chk($sformatf("dut%0d_rst_busy", d), get_busy(d), 0);
            chk($sformatf("dut%0d_rst_done", d), get_done(d), 0);
            chk($sformatf("dut%0d_rst_sat", d), get_sat(d), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            e = '{dut:tbl[i].dut, y0:tbl[i].y0, ystep:tbl[i].ystep,
                  sat:tbl[i].sat, lat:tbl[i].lat};
            run_job(tbl[i].dut, tbl[i].accum, tbl[i].wpat, tbl[i].wv,
                    tbl[i].xv, e, 0);
        end

        // Start pulsed again mid-RUN with different operands: ignored.
        e = '{dut:1, y0:0, ystep:0, sat:1'b0, lat:5};
        run_job(1, 1'b0, 2, 0, 32, e, 2);

        // Reset two cycles into RUN; dut 0 holds y=256 beforehand.
        @(negedge clk);
        set_ops(0, 1'b0, 0, 64, 64);
        set_start(0, 1'b1);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_busy_before", get_busy(0), 1);
        rst = 1'b1;
        #1;
        nz = 0;
        for (int r = 0; r < 8; r++) nz += (get_y(0, r) != 0) ? 1 : 0;
        chk("mid_rst_y", nz, 0);
        chk("mid_rst_busy", get_busy(0), 0);
        chk("mid_rst_done", get_done(0), 0);
        chk("mid_rst_sat", get_sat(0), 0);
        @(negedge clk);
        rst = 1'b0;
        e = '{dut:0, y0:256, ystep:0, sat:1'b0, lat:5};
        run_job(0, 1'b1, 0, 64, 64, e, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
